dev_fetch: RTL and testbench

- Instruction fetch unit: the producer side of the 32-bit `ir` word consumed by the instruction decoder.
- On a fetch request from the control unit, reads four consecutive bytes from byte-wide RAM at `pc`.
- Assembles them big-endian (byte at `pc` → `ir[31:24]`), holds the result stable and signals completion with a one-cycle `ir_valid` pulse.

---
 rtl/dev_fetch.sv | 142 ++++++++++++++
 tb/tb_dev_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_fetch.sv
// dev_fetch: instruction fetch unit. Reads four bytes starting at an aligned
// pc from byte-wide RAM and assembles them big-endian into ir. When ir has
// been updated, ir_valid pulses for one cycle.
// Optional single-entry word cache under `define FETCH_CACHE_EN.
`timescale 1ns/1ps

module dev_fetch #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              inval,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_valid,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       shadow;
  logic              tail;
  logic              hit_c;
  logic              timeout_c;

  // Last wait cycle without a response: the byte is given up on.
  assign timeout_c = (state == S_WAIT) && !ram_valid &&
                     (cnt == CNT_W'(TIMEOUT - 1));

  // Busy covers every non-idle state plus the ir_valid / timeout-err cycle.
  assign busy = (state != S_IDLE) | tail;

`ifdef FETCH_CACHE_EN
  logic [ADDR_W-1:0] tag;
  logic              tag_vld;

  assign hit_c = tag_vld && (pc == tag);

  // Cache tag: set by every completed fetch; inval, timeout and reset clear it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag     <= '0;
      tag_vld <= 1'b0;
    end else if (state == S_DONE) begin
      tag     <= base;
      tag_vld <= !inval;
    end else if (inval || timeout_c) begin
      tag_vld <= 1'b0;
    end
  end
`else
  logic unused_inval;

  assign hit_c        = 1'b0;
  assign unused_inval = inval;
`endif

  // Fetch sequencer: one read per byte, shadow assembly, then a single ir update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      base     <= '0;
      idx      <= 2'd0;
      cnt      <= '0;
      shadow   <= 32'h0;
      tail     <= 1'b0;
      ir       <= 32'h0;
      ir_valid <= 1'b0;
      err      <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
    end else begin
      ir_valid <= 1'b0;
      err      <= 1'b0;
      ram_rd   <= 1'b0;
      tail     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (pc[1:0] != 2'b00) begin
              err <= 1'b1;
            end else begin
              base <= pc;
              idx  <= 2'd0;
              if (hit_c) begin
                state <= S_DONE;
              end else begin
                state    <= S_REQ;
                ram_rd   <= 1'b1;
                ram_addr <= pc;
              end
            end
          end
        end
        S_REQ: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ram_valid) begin
            shadow[{~idx, 3'b000} +: 8] <= ram_rdata;
            if (idx == 2'd3) begin
              state <= S_DONE;
            end else begin
              idx      <= idx + 2'd1;
              state    <= S_REQ;
              ram_rd   <= 1'b1;
              ram_addr <= base + ADDR_W'(idx + 2'd1);
            end
          end else if (timeout_c) begin
            err   <= 1'b1;
            tail  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          ir       <= shadow;
          ir_valid <= 1'b1;
          tail     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_fetch.sv
// Self-checking bench for dev_fetch: RAM responder with per-byte latency,
// directed scenarios followed by randomized fetches against a word-level model.
`timescale 1ns/1ps

module tb_dev_fetch;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 15;
`ifdef FETCH_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              inval = 1'b0;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata = 8'h00;
  logic              ram_valid = 1'b0;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  dev_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .inval(inval),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_valid(ram_valid), .ir(ir), .ir_valid(ir_valid), .busy(busy),
    .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // RAM model and responder state
  logic [7:0]  mem [0:65535];
  int          lat_b [4];
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] rd_q [$];

  // Reference model state
  logic [31:0] m_ir = 32'h0;
  bit          m_vld = 1'b0;
  logic [15:0] m_tag = '0;

  // Responder: answers a read lat_b[byte] cycles after ram_rd; 0 = never.
  always @(posedge clk) begin
    #1;
    ram_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        ram_valid = 1'b1;
        ram_rdata = mem[pend_addr];
        pend      = 1'b0;
      end
    end
    if (ram_rd === 1'b1) begin
      rd_q.push_back(ram_addr);
      if (lat_b[ram_addr[1:0]] > 0) begin
        pend      = 1'b1;
        pend_cnt  = lat_b[ram_addr[1:0]];
        pend_addr = ram_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [15:0] p);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w = {w[23:0], mem[p + 16'(i)]};
    return w;
  endfunction

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_b[0] = l0; lat_b[1] = l1; lat_b[2] = l2; lat_b[3] = l3;
  endtask

  task automatic pulse_inval();
    @(negedge clk); inval = 1'b1;
    @(negedge clk); inval = 1'b0;
    m_vld = 1'b0;
  endtask

  task automatic run_fetch(input logic [15:0] p, input bit mid, output int cyc,
                           output bit gv, output bit ge, output bit bok);
    rd_q.delete();
    @(negedge clk);
    pc = p; start = 1'b1;
    cyc = 0; gv = 1'b0; ge = 1'b0; bok = 1'b1;
    while (cyc < 200 && !gv && !ge) begin
      @(negedge clk);
      cyc++;
      start = mid && (cyc == 3 || cyc == 5);
      if (ir_valid === 1'b1) gv = 1'b1;
      if (err === 1'b1) ge = 1'b1;
      if (busy !== 1'b1) bok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic fetch_and_check(input string tag, input logic [15:0] p, input bit mid);
    bit aligned, hit, tmo, gv, ge, bok;
    int t, exp_cyc, cyc, n_exp_rd;
    logic [31:0] exp_ir;
    aligned = (p[1:0] == 2'b00);
    hit = CACHE_ON && aligned && m_vld && (p == m_tag);
    t = 4;
    for (int i = 3; i >= 0; i--) if (lat_b[i] == 0) t = i;
    tmo = aligned && !hit && (t < 4);
    if (!aligned) begin
      exp_cyc = 1; n_exp_rd = 0;
    end else if (hit) begin
      exp_cyc = 2; n_exp_rd = 0;
    end else begin
      exp_cyc = 2;
      for (int i = 0; i < t; i++) exp_cyc += 1 + lat_b[i];
      if (tmo) begin
        exp_cyc += TIMEOUT; n_exp_rd = t + 1;
      end else begin
        n_exp_rd = 4;
      end
    end
    exp_ir = (aligned && !tmo) ? (hit ? m_ir : model_word(p)) : m_ir;

    run_fetch(p, mid, cyc, gv, ge, bok);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_ir_valid"}, 32'(gv), 32'(aligned && !tmo));
    chk({tag, "_err"}, 32'(ge), 32'(!aligned || tmo));
    chk({tag, "_ir"}, ir, exp_ir);
    chk({tag, "_busy"}, 32'(bok), 32'(aligned));
    chk({tag, "_n_rd"}, 32'(rd_q.size()), 32'(n_exp_rd));
    for (int i = 0; i < n_exp_rd && i < rd_q.size(); i++)
      chk({tag, "_addr"}, 32'(rd_q[i]), 32'(p + 16'(i)));
    @(negedge clk);
    chk({tag, "_after"}, {29'h0, busy, ir_valid, err}, 32'h0);

    if (aligned && !tmo) begin
      m_ir = exp_ir; m_vld = 1'b1; m_tag = p;
    end else if (tmo) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ir"}, ir, 32'h0);
    chk({tag, "_ir_valid"}, 32'(ir_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_ram_rd"}, 32'(ram_rd), 32'h0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
  endtask

  logic [15:0] p_r, last_p;
  int          waitc;
  bit          quiet;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    set_lat(1, 1, 1, 1);

    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic fetch at 0x0010, L=1
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    fetch_and_check("basic", 16'h0010, 1'b0);
    chk("basic_ir_const", ir, 32'h11223344);

    // Misaligned pc
    fetch_and_check("misaligned", 16'h0013, 1'b0);
    chk("misaligned_ir_const", ir, 32'h11223344);

    // Wrap at top of address space, alternating latency, start pulses mid-fetch
    set_lat(1, 3, 1, 3);
    fetch_and_check("wrap", 16'hFFFC, 1'b1);

    // Byte 2 never answered, then a normal fetch
    set_lat(1, 2, 0, 1);
    fetch_and_check("timeout", 16'h0100, 1'b0);
    set_lat(2, 2, 2, 2);
    fetch_and_check("after_to", 16'h0104, 1'b0);

    // Reset during WAIT of byte 1, late response after release
    set_lat(1, 6, 1, 1);
    rd_q.delete();
    @(negedge clk);
    pc = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitc = 0;
    while (rd_q.size() < 2 && waitc < 50) begin
      @(negedge clk); waitc++;
    end
    chk("rst_mid_reached_b1", 32'(rd_q.size()), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_reset_vals("rst_mid");
    m_ir = 32'h0; m_vld = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ir_valid !== 1'b0 || ram_rd !== 1'b0 || busy !== 1'b0 || err !== 1'b0) quiet = 1'b0;
    end
    chk("rst_mid_quiet", 32'(quiet), 32'h1);
    chk("rst_mid_ir", ir, 32'h0);

    // Same address twice, invalidate, then refetch with new contents
    set_lat(1, 1, 1, 1);
    fetch_and_check("again1", 16'h0010, 1'b0);
    fetch_and_check("again2", 16'h0010, 1'b0);
    pulse_inval();
    mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB;
    mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
    fetch_and_check("inval", 16'h0010, 1'b0);
    chk("inval_ir_const", ir, 32'hAABBCCDD);

    // Randomized fetches
    last_p = 16'h0010;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) p_r = last_p;
      else p_r = 16'($urandom_range(0, 65535)) & 16'hFFFC;
      if ($urandom_range(0, 5) == 0) p_r[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < 4; i++) mem[p_r + 16'(i)] = 8'($urandom);
      for (int i = 0; i < 4; i++) lat_b[i] = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) lat_b[$urandom_range(0, 3)] = 0;
      if ($urandom_range(0, 4) == 0) pulse_inval();
      fetch_and_check("rnd", p_r, 1'($urandom_range(0, 1)));
      last_p = p_r;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
